// File: rtl/ro_vote_collector.sv
// ro_vote_collector: gathers NUM_VOTES ring-oscillator comparison samples per
// round, majority-votes them and raises voting_done as a level for the
// VotingDone PIO. A per-sample watchdog ends a stalled round with timeout set.
module ro_vote_collector #(
  parameter int NUM_VOTES   = 15,
  parameter int CNT_W       = 5,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             sample_bit,
  output logic             busy,
  output logic             voting_done,
  output logic             vote_result,
  output logic             timeout,
  output logic [CNT_W-1:0] ones_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(NUM_VOTES - 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(NUM_VOTES / 2);
  localparam logic [TO_W-1:0]  WD_LAST  = TO_W'(TIMEOUT_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             busy_q, done_q, vote_q, to_q;

  // Next values of the counters for a cycle spent in COLLECT.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    ones_d = ones_q + CNT_W'(sample_bit);
    wd_d   = wd_q + TO_W'(1);
  end

  // Round FSM; every output is a register so the PIO sees a glitch-free level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ones_q  <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vote_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // Samples arriving here are dropped; only start moves us on.
          if (start) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            ones_q  <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            vote_q  <= 1'b0;
            to_q    <= 1'b0;
          end
        end
        COLLECT: begin
          // start is ignored here; a sample always beats the watchdog limit.
          if (sample_valid) begin
            cnt_q  <= cnt_d;
            ones_q <= ones_d;
            wd_q   <= '0;
            if (cnt_q == LAST_SMP) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              to_q    <= 1'b0;
              vote_q  <= (ones_d > HALF);
            end
          end else if (wd_q == WD_LAST) begin
            state_q <= DONE;
            wd_q    <= wd_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            to_q    <= 1'b1;
            vote_q  <= 1'b0;
          end else begin
            wd_q <= wd_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign voting_done = done_q;
  assign vote_result = vote_q;
  assign timeout     = to_q;
  assign ones_count  = ones_q;

endmodule

// File: tb/tb_ro_vote_collector.sv
// Scoreboard bench for ro_vote_collector: the driver plays whole rounds and
// pushes the round outcome; a monitor pops it when voting_done rises.
module tb_ro_vote_collector;
  localparam int NV = 15;
  localparam int CW = 5;
  localparam int TO = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          sample_valid = 1'b0;
  logic          sample_bit = 1'b0;
  logic          busy, voting_done, vote_result, timeout;
  logic [CW-1:0] ones_count;

  ro_vote_collector #(.NUM_VOTES(NV), .CNT_W(CW), .TIMEOUT_CYC(TO), .TO_W(13)) dut (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .sample_bit(sample_bit), .busy(busy), .voting_done(voting_done),
    .vote_result(vote_result), .timeout(timeout), .ones_count(ones_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int vote;
    int ones;
    int to;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  bit   have_last = 0;
  bit   prev_done = 0;
  bit   chk_start = 0;
  int   n_tests = 0, n_fail = 0, n_pushed = 0, n_seen = 0;
  int   gap_a[NV];
  bit   bit_a[NV];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop on the rising edge of voting_done, then hold-check every DONE cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 0;
      have_last = 0;
    end else begin
      if (voting_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got voting_done at cycle %0d, required none", cyc);
        end else begin
          last = exp_q.pop_front();
          have_last = 1;
          n_seen++;
          chk("done_cycle", cyc, last.cyc);
        end
      end
      if (voting_done && have_last) begin
        chk("vote_result", vote_result, last.vote);
        chk("ones_count", ones_count, last.ones);
        chk("timeout", timeout, last.to);
        chk("busy_in_done", busy, 0);
      end
      prev_done = voting_done;
    end
  end

  // One driven cycle; inputs change on the falling edge.
  task automatic step(input bit s, input bit v, input bit b);
    @(negedge clk);
    if (chk_start) begin
      chk("start_busy", busy, 1);
      chk("start_done", voting_done, 0);
      chk("start_ones", ones_count, 0);
      chk("start_to", timeout, 0);
      chk_start = 0;
    end
    start = s;
    sample_valid = v;
    sample_bit = b;
  endtask

  task automatic fill_bits(input int n_ones);
    for (int i = 0; i < NV; i++) bit_a[i] = (i < n_ones);
    for (int i = NV - 1; i > 0; i--) begin
      int j;
      bit t;
      j = $urandom_range(0, i);
      t = bit_a[i]; bit_a[i] = bit_a[j]; bit_a[j] = t;
    end
  endtask

  task automatic fill_rand_bits();
    for (int i = 0; i < NV; i++) bit_a[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_gaps(input int mx);
    for (int i = 0; i < NV; i++) gap_a[i] = $urandom_range(0, mx);
  endtask

  // Play one round. to_after: stall forever after that many samples (-1 none).
  // rst_after: assert reset after that many samples (-1 none).
  task automatic play_round(input int to_after, input int rst_after);
    int ones;
    ones = 0;
    step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk_start = 1;
    for (int k = 0; k < NV; k++) begin
      if (k == to_after) begin
        for (int i = 0; i < TO; i++) step(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
        exp_q.push_back('{0, ones, 1, cyc + 1});
        n_pushed++;
        step(0, 0, 0);
        return;
      end
      if (k == rst_after) begin
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        sample_valid = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", voting_done, 0);
        chk("rst_vote", vote_result, 0);
        chk("rst_to", timeout, 0);
        chk("rst_ones", ones_count, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      for (int i = 0; i < gap_a[k]; i++) step(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
      step(1'($urandom_range(0, 1)), 1, bit_a[k]);
      ones += int'(bit_a[k]);
    end
    exp_q.push_back('{(ones > NV / 2) ? 1 : 0, ones, 0, cyc + 1});
    n_pushed++;
    step(0, 0, 0);
  endtask

  // Linger in DONE with stray samples; the monitor checks nothing moves.
  task automatic linger();
    repeat (4) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", voting_done, 0);
    chk("reset_vote", vote_result, 0);
    chk("reset_to", timeout, 0);
    chk("reset_ones", ones_count, 0);
    reset = 1'b0;

    // Samples in IDLE are dropped.
    repeat (4) step(0, 1, 1);
    step(0, 0, 0);
    chk("idle_ones", ones_count, 0);
    chk("idle_busy", busy, 0);

    // All ones, back to back.
    fill_bits(NV); fill_gaps(0);
    play_round(-1, -1); linger();

    // 8 ones / 7 ones with gaps 0-3.
    fill_bits(8); fill_gaps(3);
    play_round(-1, -1); linger();
    fill_bits(7); fill_gaps(3);
    play_round(-1, -1); linger();

    // Watchdog expiry after 5 samples.
    fill_rand_bits(); fill_gaps(3);
    play_round(5, -1); linger();

    // Reset after sample 9, then a clean round from zero.
    fill_rand_bits(); fill_gaps(2);
    play_round(-1, 9);
    step(0, 0, 0);
    fill_rand_bits(); fill_gaps(3);
    play_round(-1, -1); linger();

    // Final sample on the watchdog-limit cycle.
    fill_rand_bits(); fill_gaps(1);
    gap_a[NV-1] = TO - 1;
    play_round(-1, -1); linger();

    // Random rounds, including all-zero.
    fill_bits(0); fill_gaps(3);
    play_round(-1, -1); linger();
    for (int r = 0; r < 8; r++) begin
      fill_rand_bits(); fill_gaps(3);
      play_round(-1, -1);
      if (r[0]) linger();
    end

    repeat (5) step(0, 0, 0);
    chk("pending_rounds", exp_q.size(), 0);
    chk("rounds_seen", n_seen, n_pushed);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: bench still running at cycle %0d, required completion", cyc);
    $fatal(1, "time limit");
  end

endmodule
